// File: rtl/inst_fetcher_pkg.sv
// Shared constants and types for the instruction fetch front end.
// Opcode encodings follow the RV32I base ISA.
package inst_fetcher_pkg;

   localparam logic [6:0] LD_TYPE   = 7'b0000011;
   localparam logic [6:0] S_TYPE    = 7'b0100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam int IQ_INST_W  = 32;
   localparam int IQ_PC_W    = 32;
   localparam int IQ_ENTRY_W = IQ_INST_W + IQ_PC_W + 1 + IQ_PC_W;

   typedef enum logic [0:0] {
      S_FETCH     = 1'b0,
      S_JALR_WAIT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [IQ_INST_W-1:0] inst;
      logic [IQ_PC_W-1:0]   pc;
      logic                 pred_taken;
      logic [IQ_PC_W-1:0]   pred_pc;
   } iq_entry_t;

endpackage

// File: rtl/inst_fetcher_inst_queue.sv
// Circular FIFO of predicted instruction entries between fetch and decode.
// Head entry is presented combinationally; an empty queue presents all zeros.
module inst_queue
   import inst_fetcher_pkg::*;
#(
   parameter int ADDR_W = 3
)
(
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            clear,
   input  logic            push,
   input  logic            pop,
   input  iq_entry_t       wr_data,
   output iq_entry_t       rd_data,
   output logic [ADDR_W:0] count
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   iq_entry_t         mem_r [DEPTH];
   logic [ADDR_W-1:0] head_r;
   logic [ADDR_W-1:0] tail_r;
   logic [ADDR_W:0]   count_r;
   logic              empty_s;
   logic              full_s;
   logic              pop_s;

   assign empty_s = (count_r == (ADDR_W+1)'(0));
   assign full_s  = (count_r == DEPTH_C);
   assign pop_s   = pop && !empty_s;
   assign count   = count_r;

   // Storage array; contents need no reset because reads are masked when empty.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_r[tail_r] <= wr_data;
      end
   end

   // Pointers wrap naturally; count tracks the simultaneous push/pop case.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head_r  <= ADDR_W'(0);
         tail_r  <= ADDR_W'(0);
         count_r <= (ADDR_W+1)'(0);
      end else if (clear) begin
         head_r  <= ADDR_W'(0);
         tail_r  <= ADDR_W'(0);
         count_r <= (ADDR_W+1)'(0);
      end else begin
         if (push) begin
            tail_r <= tail_r + ADDR_W'(1);
         end
         if (pop_s) begin
            head_r <= head_r + ADDR_W'(1);
         end
         case ({push, pop_s})
            2'b10:   count_r <= count_r + (ADDR_W+1)'(1);
            2'b01:   count_r <= count_r - (ADDR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head read, forced to zero when nothing is queued.
   always_comb begin
      rd_data = iq_entry_t'({IQ_ENTRY_W{1'b0}});
      if (!empty_s) begin
         rd_data = mem_r[head_r];
      end else begin
         rd_data = iq_entry_t'({IQ_ENTRY_W{1'b0}});
      end
   end

   inst_queue_chk #(.ADDR_W(ADDR_W)) u_chk (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (push),
      .full   (full_s)
   );

endmodule

// File: rtl/inst_queue_chk.sv
// Simulation-only checks on the instruction queue handshake.
module inst_queue_chk
#(
   parameter int ADDR_W = 3
)
(
   input logic clk_in,
   input logic rst_in,
   input logic push,
   input logic full
);

   // The fetcher never has a request outstanding when the queue is full.
   a_no_push_when_full: assert property (@(posedge clk_in) disable iff (rst_in) !(push && full))
      else $error("inst_queue: push while full (ADDR_W=%0d)", ADDR_W);

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: one outstanding fetch, static next-PC prediction,
// and an instruction queue feeding the decoder.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int          IQ_ADDR_W = 3,
   parameter logic [31:0] RESET_PC  = 32'h0
)
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear_up,
   input  logic [31:0] rob_new_pc,
   input  logic        jalr_resolved,
   input  logic [31:0] jalr_target,
   output logic        should_fetch,
   output logic [31:0] pc,
   input  logic        fetch_ready,
   input  logic [31:0] inst,
   input  logic [31:0] inst_addr,
   output logic        iq_valid,
   output logic [31:0] iq_inst,
   output logic [31:0] iq_pc,
   output logic        iq_pred_taken,
   output logic [31:0] iq_pred_pc,
   input  logic        dec_pop
);

   localparam logic [IQ_ADDR_W:0] IQ_DEPTH = (IQ_ADDR_W+1)'(1) << IQ_ADDR_W;

   fetch_state_e       state_r;
   logic [31:0]        fetch_pc_r;
   logic [IQ_ADDR_W:0] iq_count_s;
   logic               accept_s;
   logic               pop_s;
   logic               is_jalr_s;
   logic               pred_taken_s;
   logic [31:0]        pred_pc_s;
   logic [31:0]        j_imm_s;
   logic [31:0]        b_imm_s;
   iq_entry_t          push_entry_s;
   iq_entry_t          head_s;

   // Requests stay asserted while waiting: count cannot grow until a response lands.
   assign should_fetch = !rst_in && (state_r == S_FETCH) && (iq_count_s < IQ_DEPTH);
   assign pc           = fetch_pc_r;

   assign accept_s = rdy_in && !rob_clear_up && fetch_ready
                     && (state_r == S_FETCH) && (inst_addr == fetch_pc_r);
   assign pop_s    = rdy_in && !rob_clear_up && dec_pop;

   // Static prediction: JAL taken, backward branch taken, JALR stalls fetch.
   always_comb begin
      j_imm_s      = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      b_imm_s      = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      pred_taken_s = 1'b0;
      pred_pc_s    = inst_addr + 32'd4;
      is_jalr_s    = 1'b0;
      case (inst[6:0])
         OP_JAL: begin
            pred_taken_s = 1'b1;
            pred_pc_s    = inst_addr + j_imm_s;
         end
         OP_BRANCH: begin
            if (inst[31]) begin
               pred_taken_s = 1'b1;
               pred_pc_s    = inst_addr + b_imm_s;
            end else begin
               pred_taken_s = 1'b0;
               pred_pc_s    = inst_addr + 32'd4;
            end
         end
         OP_JALR: begin
            is_jalr_s = 1'b1;
         end
         default: begin
            pred_taken_s = 1'b0;
            pred_pc_s    = inst_addr + 32'd4;
         end
      endcase
   end

   assign push_entry_s = '{inst: inst, pc: inst_addr, pred_taken: pred_taken_s, pred_pc: pred_pc_s};

   // Fetch sequencing; a ROB flush overrides everything, including a frozen pipeline.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r    <= S_FETCH;
         fetch_pc_r <= RESET_PC;
      end else if (rob_clear_up) begin
         state_r    <= S_FETCH;
         fetch_pc_r <= rob_new_pc;
      end else if (!rdy_in) begin
         state_r    <= state_r;
         fetch_pc_r <= fetch_pc_r;
      end else begin
         case (state_r)
            S_FETCH: begin
               if (accept_s && is_jalr_s) begin
                  state_r <= S_JALR_WAIT;
               end else if (accept_s) begin
                  fetch_pc_r <= pred_pc_s;
               end else begin
                  state_r <= S_FETCH;
               end
            end
            S_JALR_WAIT: begin
               if (jalr_resolved) begin
                  fetch_pc_r <= jalr_target;
                  state_r    <= S_FETCH;
               end else begin
                  state_r <= S_JALR_WAIT;
               end
            end
            default: begin
               state_r <= S_FETCH;
            end
         endcase
      end
   end

   inst_queue #(.ADDR_W(IQ_ADDR_W)) u_iq (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clear   (rob_clear_up),
      .push    (accept_s),
      .pop     (pop_s),
      .wr_data (push_entry_s),
      .rd_data (head_s),
      .count   (iq_count_s)
   );

   assign iq_valid      = (iq_count_s != (IQ_ADDR_W+1)'(0));
   assign iq_inst       = head_s.inst;
   assign iq_pc         = head_s.pc;
   assign iq_pred_taken = head_s.pred_taken;
   assign iq_pred_pc    = head_s.pred_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench: the bench plays the memory controller and decoder; a monitor
// checks every dequeued entry against a reference predictor.
module tb_inst_fetcher;

   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_BR   = 7'b1100011;
   localparam logic [6:0] OPC_JALR = 7'b1100111;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, rob_clear_up, jalr_resolved, fetch_ready, dec_pop;
   logic [31:0] rob_new_pc, jalr_target, inst, inst_addr;
   logic        should_fetch, iq_valid, iq_pred_taken;
   logic [31:0] pc, iq_inst, iq_pc, iq_pred_pc;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] pred;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   bit          run_mon = 1'b0;
   bit          rnd_pop = 1'b0;
   logic [31:0] model_pc;
   bit          model_wait;

   always #5 clk_in = ~clk_in;

   inst_fetcher #(.IQ_ADDR_W(3), .RESET_PC(32'h0)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .rob_clear_up  (rob_clear_up),
      .rob_new_pc    (rob_new_pc),
      .jalr_resolved (jalr_resolved),
      .jalr_target   (jalr_target),
      .should_fetch  (should_fetch),
      .pc            (pc),
      .fetch_ready   (fetch_ready),
      .inst          (inst),
      .inst_addr     (inst_addr),
      .iq_valid      (iq_valid),
      .iq_inst       (iq_inst),
      .iq_pc         (iq_pc),
      .iq_pred_taken (iq_pred_taken),
      .iq_pred_pc    (iq_pred_pc),
      .dec_pop       (dec_pop)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference predictor: offsets rebuilt by weighting each immediate field.
   function automatic exp_t predict(input logic [31:0] w, input logic [31:0] a);
      exp_t        e;
      logic [31:0] off;
      e.inst  = w;
      e.pc    = a;
      e.taken = 1'b0;
      e.pred  = a + 32'd4;
      if (w[6:0] == OPC_JAL) begin
         off = 32'(w[30:21]) * 2 + 32'(w[20]) * 2048 + 32'(w[19:12]) * 4096
               - (w[31] ? 32'h0010_0000 : 32'h0);
         e.taken = 1'b1;
         e.pred  = a + off;
      end else if (w[6:0] == OPC_BR && w[31]) begin
         off = 32'(w[11:8]) * 2 + 32'(w[30:25]) * 32 + 32'(w[7]) * 2048 - 32'h0000_1000;
         e.taken = 1'b1;
         e.pred  = a + off;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_word();
      logic [31:0] x;
      int          r;
      x = $urandom;
      r = $urandom_range(0, 9);
      if (r < 3)       return {x[31:7], OPC_JAL};
      else if (r < 6)  return {x[31:7], OPC_BR};
      else if (r == 6) return {x[31:7], OPC_JALR};
      else             return {x[31:7], 7'b0010011};
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
      if (rnd_pop) dec_pop = 1'($urandom_range(0, 1));
   endtask

   // Memory-controller side: wait for a request, answer it, record the expectation.
   task automatic respond(input logic [31:0] w, input bit pop_too);
      int   n = 0;
      exp_t e;
      while (!should_fetch && n < 100) begin
         step();
         n++;
      end
      if (!should_fetch) begin
         chk("req_timeout", 32'(should_fetch), 32'd1);
         return;
      end
      chk("req_pc", pc, model_pc);
      fetch_ready = 1'b1;
      inst        = w;
      inst_addr   = model_pc;
      dec_pop     = pop_too;
      e = predict(w, model_pc);
      step();
      fetch_ready = 1'b0;
      exp_q.push_back(e);
      if (w[6:0] == OPC_JALR) model_wait = 1'b1;
      else                    model_pc = e.pred;
      if (!rnd_pop) dec_pop = 1'b0;
   endtask

   task automatic flush(input logic [31:0] npc, input bit with_resp, input bit with_jalr, input bit rdy);
      rob_clear_up  = 1'b1;
      rob_new_pc    = npc;
      rdy_in        = rdy;
      fetch_ready   = with_resp;
      inst          = 32'h0000_0013;
      inst_addr     = model_pc;
      jalr_resolved = with_jalr;
      jalr_target   = npc ^ 32'h0000_0F00;
      step();
      rob_clear_up  = 1'b0;
      fetch_ready   = 1'b0;
      jalr_resolved = 1'b0;
      rdy_in        = 1'b1;
      exp_q.delete();
      model_pc   = npc;
      model_wait = 1'b0;
      chk("flush_empty", 32'(iq_valid), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      dec_pop = 1'b1;
      while (exp_q.size() > 0 && n < 50) begin
         step();
         n++;
      end
      dec_pop = 1'b0;
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Frozen pipeline: responses, pops and JALR resolutions must all be ignored.
   task automatic freeze(input int k);
      logic [31:0] x;
      rdy_in = 1'b0;
      repeat (k) begin
         x             = $urandom;
         fetch_ready   = 1'b1;
         inst          = x;
         inst_addr     = model_pc;
         jalr_resolved = model_wait;
         jalr_target   = x;
         step();
      end
      rdy_in        = 1'b1;
      fetch_ready   = 1'b0;
      jalr_resolved = 1'b0;
   endtask

   // Scoreboard monitor: occupancy agreement every cycle, entry contents on each pop.
   always @(negedge clk_in) begin
      exp_t e;
      if (run_mon && !rst_in) begin
         chk("iq_valid", 32'(iq_valid), 32'(exp_q.size() != 0));
         if (rdy_in && !rob_clear_up && dec_pop && iq_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("head_inst", iq_inst, e.inst);
            chk("head_pc", iq_pc, e.pc);
            chk("head_taken", 32'(iq_pred_taken), 32'(e.taken));
            chk("head_pred_pc", iq_pred_pc, e.pred);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] t;
      rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0; rob_new_pc = 32'h0;
      jalr_resolved = 1'b0; jalr_target = 32'h0; fetch_ready = 1'b0;
      inst = 32'h0; inst_addr = 32'h0; dec_pop = 1'b0;
      model_pc = 32'h0; model_wait = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_should_fetch", 32'(should_fetch), 32'd0);
      chk("rst_iq_valid", 32'(iq_valid), 32'd0);
      chk("rst_iq_inst", iq_inst, 32'd0);
      chk("rst_iq_pc", iq_pc, 32'd0);
      chk("rst_iq_taken", 32'(iq_pred_taken), 32'd0);
      chk("rst_iq_pred_pc", iq_pred_pc, 32'd0);
      chk("rst_pc", pc, 32'd0);
      rst_in = 1'b0;
      #1;
      chk("post_rst_fetch", 32'(should_fetch), 32'd1);
      run_mon = 1'b1;

      respond(32'h0000_0013, 1'b0);
      chk("nop_pc", iq_pc, 32'h0);
      chk("nop_pred", iq_pred_pc, 32'h4);
      respond(32'h0000_0013, 1'b0);
      drain();

      flush(32'h10, 1'b0, 1'b0, 1'b1);
      respond(32'h0080_006F, 1'b0);
      chk("jal_taken", 32'(iq_pred_taken), 32'd1);
      chk("jal_pred", iq_pred_pc, 32'h18);
      respond(32'h0000_0013, 1'b0);
      drain();

      flush(32'h20, 1'b0, 1'b0, 1'b1);
      respond(32'hFE00_0EE3, 1'b0);
      chk("bwd_taken", 32'(iq_pred_taken), 32'd1);
      chk("bwd_pred", iq_pred_pc, 32'h1C);
      respond(32'h0000_0463, 1'b0);
      respond(32'h0000_0013, 1'b0);
      drain();

      flush(32'h30, 1'b0, 1'b0, 1'b1);
      respond(32'h0000_8067, 1'b0);
      repeat (4) begin
         step();
         chk("jalr_stall", 32'(should_fetch), 32'd0);
      end
      jalr_resolved = 1'b1; jalr_target = 32'h100;
      step();
      jalr_resolved = 1'b0;
      model_pc = 32'h100; model_wait = 1'b0;
      respond(32'h0000_0013, 1'b0);
      jalr_resolved = 1'b1; jalr_target = 32'h500;
      step();
      jalr_resolved = 1'b0;
      respond(32'h0000_0013, 1'b0);
      drain();

      fetch_ready = 1'b1; inst = 32'h0000_0013; inst_addr = model_pc ^ 32'h40;
      step();
      fetch_ready = 1'b0;
      chk("stale_drop", 32'(iq_valid), 32'd0);

      repeat (8) respond(32'h0000_0013, 1'b0);
      step();
      chk("full_stop", 32'(should_fetch), 32'd0);
      dec_pop = 1'b1;
      step();
      dec_pop = 1'b0;
      chk("resume", 32'(should_fetch), 32'd1);
      respond(32'h0000_0013, 1'b1);
      chk("pushpop_count", 32'(should_fetch), 32'd1);
      respond(32'h0000_0013, 1'b0);
      chk("refull", 32'(should_fetch), 32'd0);
      drain();

      repeat (5) respond(32'h0000_0013, 1'b0);
      flush(32'h200, 1'b1, 1'b1, 1'b1);
      respond(32'h0000_0013, 1'b0);
      flush(32'h300, 1'b1, 1'b0, 1'b0);
      respond(32'h0000_0013, 1'b0);
      drain();

      rnd_pop = 1'b1;
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (model_wait && r < 20) begin
            freeze($urandom_range(1, 3));
         end else if (model_wait) begin
            repeat ($urandom_range(0, 3)) begin
               step();
               chk("jalr_stall_rnd", 32'(should_fetch), 32'd0);
            end
            t = $urandom;
            jalr_resolved = 1'b1; jalr_target = t;
            step();
            jalr_resolved = 1'b0;
            model_pc = t; model_wait = 1'b0;
         end else if (r < 5) begin
            t = $urandom;
            flush(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else if (r < 10) begin
            freeze($urandom_range(1, 3));
         end else begin
            respond(gen_word(), 1'($urandom_range(0, 1)));
         end
      end
      rnd_pop = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
